joybus_poll_sched: RTL and testbench



---
 rtl/joybus_poll_sched.sv | 159 +++++++++++++++
 tb/tb_joybus_poll_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/joybus_poll_sched.sv
`timescale 1ns/1ps
// JOYBUS command scheduler: auto-poll vs manual arbitration, ORIGIN handshake, timeout with bounded retry.
// Optional build macro JOYBUS_SCHED_STATS_EN adds saturating ok/err transaction counters.
module joybus_poll_sched #(
  parameter int POLL_CYCLES    = 500000,
  parameter int TIMEOUT_CYCLES = 2500,
  parameter int GAP_CYCLES     = 25,
  parameter int MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        auto_en,
  input  logic        manual_req,
  input  logic [7:0]  manual_cmd,
  output logic        manual_done,
  output logic        cmd_rdy,
  output logic [7:0]  cmd_data,
  input  logic        tx_done,
  input  logic        rx_done,
  input  logic        rx_err,
  input  logic [31:0] rx_data,
  output logic [31:0] cntlr_data,
  output logic        cntlr_data_vld,
  output logic        origin_done,
  output logic        link_err,
  output logic        busy,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt
);
  localparam int PW = $clog2(POLL_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [7:0]    CMD_ORIGIN = 8'h00;
  localparam logic [7:0]    CMD_POLL   = 8'h01;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_TX, WAIT_RX, GAP} state_t;
  state_t state, state_nxt;

  logic [PW-1:0] poll_cnt;
  logic [TW-1:0] to_cnt;
  logic [GW-1:0] gap_cnt;
  logic [RW-1:0] retry_cnt, retry_inc;
  logic          poll_pend, poll_wrap, poll_take;
  logic          src_manual, retry_pend;
  logic          rx_ok, rx_fail, drop;

  assign poll_wrap = auto_en && (poll_cnt == POLL_LAST);
  assign poll_take = (state == IDLE) && !manual_req && poll_pend;
  assign rx_ok     = (state == WAIT_RX) && rx_done && !rx_err;
  // rx_done wins over the timeout in the last count cycle
  assign rx_fail   = (state == WAIT_RX) && (rx_done ? rx_err : (to_cnt == TO_LAST));
  assign retry_inc = retry_cnt + RW'(1);
  assign drop      = rx_fail && (retry_inc >= RETRY_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (manual_req || poll_pend) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT_TX;
      WAIT_TX: if (tx_done) state_nxt = WAIT_RX;
      WAIT_RX: if (rx_ok || rx_fail) state_nxt = GAP;
      GAP:     if (gap_cnt == GAP_LAST) state_nxt = retry_pend ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_rdy = (state == ISSUE);
    busy    = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_cnt       <= '0;
      poll_pend      <= 1'b0;
      to_cnt         <= '0;
      gap_cnt        <= '0;
      retry_cnt      <= '0;
      retry_pend     <= 1'b0;
      src_manual     <= 1'b0;
      cmd_data       <= '0;
      cntlr_data     <= '0;
      cntlr_data_vld <= 1'b0;
      origin_done    <= 1'b0;
      manual_done    <= 1'b0;
      link_err       <= 1'b0;
    end else begin
      cntlr_data_vld <= 1'b0;
      manual_done    <= 1'b0;
      link_err       <= 1'b0;
      // a wrap while a poll is still pending is simply absorbed
      if (!auto_en) poll_cnt <= '0;
      else          poll_cnt <= poll_wrap ? '0 : poll_cnt + PW'(1);
      poll_pend <= auto_en && ((poll_pend && !poll_take) || poll_wrap);

      if (state == IDLE) begin
        if (manual_req) begin
          cmd_data   <= manual_cmd;
          src_manual <= 1'b1;
        end else if (poll_pend) begin
          cmd_data   <= origin_done ? CMD_POLL : CMD_ORIGIN;
          src_manual <= 1'b0;
        end
      end

      to_cnt  <= (state == WAIT_RX) ? to_cnt + TW'(1) : '0;
      gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;

      if (rx_ok) begin
        retry_cnt   <= '0;
        retry_pend  <= 1'b0;
        manual_done <= src_manual;
        if (cmd_data == CMD_POLL) begin
          cntlr_data     <= rx_data;
          cntlr_data_vld <= 1'b1;
        end
        if (cmd_data == CMD_ORIGIN) origin_done <= 1'b1;
      end else if (drop) begin
        retry_cnt   <= '0;
        retry_pend  <= 1'b0;
        link_err    <= 1'b1;
        origin_done <= 1'b0;
        manual_done <= src_manual;
      end else if (rx_fail) begin
        retry_cnt  <= retry_inc;
        retry_pend <= 1'b1;
      end
    end
  end

`ifdef JOYBUS_SCHED_STATS_EN
  logic [15:0] ok_q, err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_q  <= '0;
      err_q <= '0;
    end else begin
      if (rx_ok && ok_q != 16'hFFFF)    ok_q  <= ok_q + 16'd1;
      if (rx_fail && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
    end
  end
  assign ok_cnt  = ok_q;
  assign err_cnt = err_q;
`else
  assign ok_cnt  = '0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_joybus_poll_sched.sv
`timescale 1ns/1ps
// Directed bench for joybus_poll_sched: startup ORIGIN, priority, rx_err retry, timeout edge,
// timeout drop, reset mid-transaction and auto_en drop, against a scripted transmitter/receiver.
module tb_joybus_poll_sched;
  localparam int POLL = 100, TO = 20, GAP = 4, MR = 3;

  logic        clk = 1'b0, rst = 1'b1, auto_en = 1'b0, manual_req = 1'b0;
  logic [7:0]  manual_cmd = 8'h00;
  logic        tx_done = 1'b0, rx_done = 1'b0, rx_err = 1'b0;
  logic [31:0] rx_data = '0;
  logic        manual_done, cmd_rdy, cntlr_data_vld, origin_done, link_err, busy;
  logic [7:0]  cmd_data;
  logic [31:0] cntlr_data;
  logic [15:0] ok_cnt, err_cnt;

  joybus_poll_sched #(.POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .auto_en(auto_en), .manual_req(manual_req), .manual_cmd(manual_cmd),
    .manual_done(manual_done), .cmd_rdy(cmd_rdy), .cmd_data(cmd_data), .tx_done(tx_done),
    .rx_done(rx_done), .rx_err(rx_err), .rx_data(rx_data), .cntlr_data(cntlr_data),
    .cntlr_data_vld(cntlr_data_vld), .origin_done(origin_done), .link_err(link_err),
    .busy(busy), .ok_cnt(ok_cnt), .err_cnt(err_cnt));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0, t0 = 0;
  int n_rdy = 0, n_vld = 0, n_lerr = 0, n_mdone = 0, last_rdy_cyc = 0;
  logic [7:0] cmd_log [64];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // pulse monitor, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (cmd_rdy) begin
      cmd_log[n_rdy] = cmd_data;
      n_rdy++;
      last_rdy_cyc = cyc;
    end
    if (cntlr_data_vld) n_vld++;
    if (link_err)       n_lerr++;
    if (manual_done)    n_mdone++;
  end

  // scripted PHY: tx_done 10 cycles after cmd_rdy, then rx_done rx_dly cycles later
  int          rx_dly = 3, n_reply = 0, err_at = -1;
  bit          resp_never = 1'b0;
  logic [31:0] reply = '0;
  initial forever begin
    @(negedge clk);
    if (cmd_rdy) begin
      repeat (10) @(posedge clk);
      #1 tx_done = 1'b1;
      @(posedge clk);
      #1 tx_done = 1'b0;
      if (!resp_never) begin
        repeat (rx_dly) @(posedge clk);
        #1 rx_done = 1'b1; rx_err = (n_reply == err_at); rx_data = reply;
        @(posedge clk);
        #1 rx_done = 1'b0; rx_err = 1'b0;
        n_reply++;
      end
    end
  end

  task automatic wait_rdy(input int budget, output bit ok);
    int n0;
    n0 = n_rdy; ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (n_rdy != n0) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic goto_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if ({busy, cmd_rdy, manual_done, cntlr_data_vld, origin_done, link_err} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000000", {busy, cmd_rdy, manual_done, cntlr_data_vld, origin_done, link_err}); end
    n_chk++; if (cmd_data !== 8'h00 || cntlr_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got cmd %h data %h want 00/0", cmd_data, cntlr_data); end
    n_chk++; if (ok_cnt !== 16'h0 || err_cnt !== 16'h0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", ok_cnt, err_cnt); end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_chk++; if (n_rdy !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_quiet: got rdy=%0d busy=%b want 0/0", n_rdy, busy); end
  endtask

  task automatic test_startup_origin;
    bit ok; int v0;
    reply = 32'hDEADBEEF;
    auto_en = 1'b1; t0 = cyc; v0 = n_vld;
    wait_rdy(150, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL origin_wait: got timeout want cmd_rdy"); end
    n_chk++; if (last_rdy_cyc - t0 !== POLL + 1) begin
      n_fail++; $display("FAIL first_poll_lat: got %0d want %0d", last_rdy_cyc - t0, POLL + 1); end
    n_chk++; if (cmd_log[n_rdy-1] !== 8'h00) begin
      n_fail++; $display("FAIL origin_cmd: got %h want 00", cmd_log[n_rdy-1]); end
    wait_idle(60, ok);
    n_chk++; if (origin_done !== 1'b1 || n_vld !== v0) begin
      n_fail++; $display("FAIL origin_done: got %b vld=%0d want 1 vld=0", origin_done, n_vld - v0); end
    wait_rdy(150, ok);
    n_chk++; if (!ok || cmd_log[n_rdy-1] !== 8'h01) begin
      n_fail++; $display("FAIL poll_cmd: got %h ok=%b want 01", cmd_log[n_rdy-1], ok); end
    wait_idle(60, ok);
    n_chk++; if (cntlr_data !== 32'hDEADBEEF || n_vld - v0 !== 1) begin
      n_fail++; $display("FAIL poll_data: got %h vld=%0d want deadbeef vld=1", cntlr_data, n_vld - v0); end
  endtask

  task automatic test_priority;
    bit ok; int r0, m0;
    goto_cyc(t0 + 300);              // poll_pend was just set at this edge
    r0 = n_rdy; m0 = n_mdone;
    manual_req = 1'b1; manual_cmd = 8'h41;
    wait_rdy(5, ok);
    manual_req = 1'b0;
    n_chk++; if (!ok || cmd_log[n_rdy-1] !== 8'h41) begin
      n_fail++; $display("FAIL prio_manual: got %h ok=%b want 41", cmd_log[n_rdy-1], ok); end
    wait_rdy(60, ok);
    n_chk++; if (!ok || cmd_log[n_rdy-1] !== 8'h01) begin
      n_fail++; $display("FAIL prio_poll: got %h ok=%b want 01", cmd_log[n_rdy-1], ok); end
    goto_cyc(t0 + 395);
    n_chk++; if (n_rdy - r0 !== 2 || n_mdone - m0 !== 1) begin
      n_fail++; $display("FAIL prio_counts: got rdy=%0d mdone=%0d want 2/1", n_rdy - r0, n_mdone - m0); end
  endtask

  task automatic test_rx_err;
    bit ok; int r0, v0, l0; logic [15:0] ok0, er0;
    r0 = n_rdy; v0 = n_vld; l0 = n_lerr; ok0 = ok_cnt; er0 = err_cnt;
    reply = 32'h12345678; err_at = n_reply;
    wait_rdy(120, ok);
    wait_idle(100, ok);
    n_chk++; if (!ok || n_rdy - r0 !== 2 || n_lerr !== l0) begin
      n_fail++; $display("FAIL rxerr_retry: got rdy=%0d lerr=%0d want 2/0", n_rdy - r0, n_lerr - l0); end
    n_chk++; if (cntlr_data !== 32'h12345678 || n_vld - v0 !== 1) begin
      n_fail++; $display("FAIL rxerr_data: got %h vld=%0d want 12345678 vld=1", cntlr_data, n_vld - v0); end
`ifdef JOYBUS_SCHED_STATS_EN
    n_chk++; if (ok_cnt - ok0 !== 16'd1 || err_cnt - er0 !== 16'd1) begin
      n_fail++; $display("FAIL rxerr_stats: got ok+%0d err+%0d want 1/1", ok_cnt - ok0, err_cnt - er0); end
`else
    n_chk++; if (ok_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rxerr_stats: got %0d/%0d want 0/0", ok_cnt, err_cnt); end
`endif
  endtask

  task automatic test_timeout_edge;
    bit ok; int r0, v0;
    r0 = n_rdy; v0 = n_vld;
    reply = 32'hCAFEF00D; rx_dly = 19;   // rx_done lands in the last timeout cycle
    wait_rdy(120, ok);
    wait_idle(80, ok);
    n_chk++; if (!ok || n_rdy - r0 !== 1 || cntlr_data !== 32'hCAFEF00D || n_vld - v0 !== 1) begin
      n_fail++; $display("FAIL to_edge: got rdy=%0d data=%h vld=%0d want 1/cafef00d/1", n_rdy - r0, cntlr_data, n_vld - v0); end
    rx_dly = 3;
  endtask

  task automatic test_timeout_drop;
    bit ok; int c1, c2, c3, l0; logic [15:0] er0;
    l0 = n_lerr; er0 = err_cnt;
    resp_never = 1'b1;
    wait_rdy(120, ok); c1 = last_rdy_cyc;
    wait_rdy(50, ok);  c2 = last_rdy_cyc;
    wait_rdy(50, ok);  c3 = last_rdy_cyc;
    n_chk++; if (c2 - c1 !== 35 || c3 - c2 !== 35) begin
      n_fail++; $display("FAIL to_spacing: got %0d/%0d want 35/35", c2 - c1, c3 - c2); end
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk); #1;
      if (n_lerr != l0) ok = 1'b1;
    end
    resp_never = 1'b0;
    n_chk++; if (!ok || origin_done !== 1'b0) begin
      n_fail++; $display("FAIL to_drop: got lerr_seen=%b origin=%b want 1/0", ok, origin_done); end
`ifdef JOYBUS_SCHED_STATS_EN
    n_chk++; if (err_cnt - er0 !== 16'd3) begin
      n_fail++; $display("FAIL to_stats: got err+%0d want 3", err_cnt - er0); end
`endif
    wait_rdy(50, ok);
    n_chk++; if (!ok || cmd_log[n_rdy-1] !== 8'h00 || n_lerr - l0 !== 1) begin
      n_fail++; $display("FAIL to_reorigin: got %h lerr=%0d want 00/1", cmd_log[n_rdy-1], n_lerr - l0); end
    wait_idle(60, ok);
    n_chk++; if (origin_done !== 1'b1) begin
      n_fail++; $display("FAIL to_origin_back: got %b want 1", origin_done); end
  endtask

  task automatic test_reset_mid;
    bit ok; int c, r0, v0;
    wait_rdy(120, ok);
    c = last_rdy_cyc;
    goto_cyc(c + 12);                    // receiver wait state
    rst = 1'b1; auto_en = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0 || origin_done !== 1'b0 || cntlr_data !== 32'h0 || cmd_rdy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_clear: got busy=%b org=%b data=%h rdy=%b want 0/0/0/0", busy, origin_done, cntlr_data, cmd_rdy); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    r0 = n_rdy; v0 = n_vld;
    repeat (50) @(posedge clk);
    #1;
    n_chk++; if (n_rdy !== r0 || n_vld !== v0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_quiet: got rdy=%0d vld=%0d busy=%b want 0/0/0", n_rdy - r0, n_vld - v0, busy); end
  endtask

  task automatic test_auto_drop;
    bit ok; int t1, r0;
    r0 = n_rdy;
    auto_en = 1'b1; t1 = cyc;
    wait_rdy(150, ok);
    auto_en = 1'b0;
    n_chk++; if (!ok || last_rdy_cyc - t1 !== POLL + 1 || cmd_log[n_rdy-1] !== 8'h00) begin
      n_fail++; $display("FAIL drop_issue: got lat=%0d cmd=%h want %0d/00", last_rdy_cyc - t1, cmd_log[n_rdy-1], POLL + 1); end
    wait_idle(60, ok);
    n_chk++; if (!ok || origin_done !== 1'b1) begin
      n_fail++; $display("FAIL drop_complete: got idle=%b origin=%b want 1/1", ok, origin_done); end
    repeat (300) @(posedge clk);
    #1;
    n_chk++; if (n_rdy - r0 !== 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL drop_quiet: got rdy=%0d busy=%b want 1/0", n_rdy - r0, busy); end
  endtask

  initial begin
    test_reset;
    test_startup_origin;
    test_priority;
    test_rx_err;
    test_timeout_edge;
    test_timeout_drop;
    test_reset_mid;
    test_auto_drop;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
